// File: rtl/vie_exe_stage_pkg.sv
// Shared types, bus layouts and store-lane helpers for the execute stage.
// Imported by the interface, the top and the divider.
package vie_exe_stage_pkg;

  localparam int VDSBUS = 144;
  localparam int VRSBUS = 73;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0, ALU_SUB  = 4'h1, ALU_SLT  = 4'h2, ALU_SLTU = 4'h3,
    ALU_AND  = 4'h4, ALU_OR   = 4'h5, ALU_XOR  = 4'h6, ALU_NOR  = 4'h7,
    ALU_SLL  = 4'h8, ALU_SRL  = 4'h9, ALU_SRA  = 4'hA, ALU_LUI  = 4'hB,
    ALU_DIV  = 4'hC, ALU_DIVU = 4'hD, ALU_REM  = 4'hE, ALU_REMU = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_RSV = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    alu_op_e     alu_op;
    logic        load;
    logic        store;
    mem_size_e   size;
    logic [6:0]  dest;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] st_data;
    logic [31:0] pc;
  } ds_payload_t;

  typedef struct packed {
    logic        valid;
    ds_payload_t pl;
  } ds_bus_t;

  typedef struct packed {
    logic        valid;
    logic        res_from_mem;
    logic [6:0]  dest;
    logic [31:0] fixres;
    logic [31:0] pc;
  } rs_bus_t;

  function automatic logic [3:0] store_wen(input mem_size_e size, input logic [1:0] lo);
    logic [3:0] wen;
    case (size)
      SZ_B:    wen = 4'b0001 << lo;
      SZ_H:    wen = lo[1] ? 4'b1100 : 4'b0011;
      SZ_W:    wen = 4'b1111;
      default: wen = 4'b0000;
    endcase
    return wen;
  endfunction

  function automatic logic [31:0] store_wdata(input mem_size_e size, input logic [31:0] data);
    logic [31:0] wd;
    case (size)
      SZ_B:    wd = {4{data[7:0]}};
      SZ_H:    wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/vie_exe_stage_if.sv
// Decode-to-memory handshake and data-SRAM request bundle of the execute stage.
// slave = the execute stage, master = the surrounding pipeline.
interface vie_exe_stage_if;
  import vie_exe_stage_pkg::*;

  logic [VDSBUS-1:0] dsbus_i;
  logic              ms_allowin;
  logic              es_allowin;
  logic [VRSBUS-1:0] rsbus_o;
  logic              data_sram_en;
  logic [3:0]        data_sram_wen;
  logic [31:0]       data_sram_addr;
  logic [31:0]       data_sram_wdata;

  modport master (
    output dsbus_i, ms_allowin,
    input  es_allowin, rsbus_o, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

  modport slave (
    input  dsbus_i, ms_allowin,
    output es_allowin, rsbus_o, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/vie_div.sv
// Iterative 32-step restoring divider, signed or unsigned, with divide-by-zero and
// overflow fixup applied as the result is captured.
module vie_div
  import vie_exe_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        busy,
  output logic        done,
  input  logic        ack,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  div_state_e  state_r;
  logic [4:0]  cnt_r;
  logic        sgn_r;
  logic [31:0] x_r, y_r, ay_r, dvd_r, part_r, quo_r, rem_r;

  logic [31:0] ax_s, ay_s, next_part_s, next_dvd_s, fix_quo_s, fix_rem_s;
  logic [32:0] shift_s, diff_s;
  logic        take_s;

  assign ax_s = (signed_op && x[31]) ? (32'd0 - x) : x;
  assign ay_s = (signed_op && y[31]) ? (32'd0 - y) : y;

  // One restoring step: shift in the next dividend bit and subtract if it fits.
  always_comb begin
    shift_s     = {part_r, dvd_r[31]};
    diff_s      = shift_s - {1'b0, ay_r};
    take_s      = ~diff_s[32];
    next_part_s = take_s ? diff_s[31:0] : shift_s[31:0];
    next_dvd_s  = {dvd_r[30:0], take_s};
  end

  // Sign restore plus divide-by-zero and INT_MIN/-1 fixups on the final step.
  always_comb begin
    fix_quo_s = next_dvd_s;
    fix_rem_s = next_part_s;
    if (y_r == 32'h0000_0000) begin
      fix_quo_s = 32'hFFFF_FFFF;
      fix_rem_s = x_r;
    end else if (sgn_r && (x_r == 32'h8000_0000) && (y_r == 32'hFFFF_FFFF)) begin
      fix_quo_s = 32'h8000_0000;
      fix_rem_s = 32'h0000_0000;
    end else begin
      fix_quo_s = (sgn_r && (x_r[31] ^ y_r[31])) ? (32'd0 - next_dvd_s) : next_dvd_s;
      fix_rem_s = (sgn_r && x_r[31]) ? (32'd0 - next_part_s) : next_part_s;
    end
  end

  // Divider FSM and datapath registers; only state and counter are reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= DIV_IDLE;
      cnt_r   <= 5'd0;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (start) begin
            x_r     <= x;
            y_r     <= y;
            sgn_r   <= signed_op;
            ay_r    <= ay_s;
            dvd_r   <= ax_s;
            part_r  <= 32'd0;
            cnt_r   <= 5'd0;
            state_r <= DIV_BUSY;
          end else begin
            state_r <= DIV_IDLE;
          end
        end
        DIV_BUSY: begin
          part_r <= next_part_s;
          dvd_r  <= next_dvd_s;
          cnt_r  <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            quo_r   <= fix_quo_s;
            rem_r   <= fix_rem_s;
            state_r <= DIV_DONE;
          end else begin
            state_r <= DIV_BUSY;
          end
        end
        DIV_DONE: begin
          if (ack) begin
            state_r <= DIV_IDLE;
          end else begin
            state_r <= DIV_DONE;
          end
        end
        default: state_r <= DIV_IDLE;
      endcase
    end
  end

  assign busy = (state_r == DIV_BUSY);
  assign done = (state_r == DIV_DONE);
  assign quo  = quo_r;
  assign rem  = rem_r;

endmodule

// File: rtl/vie_exe_stage.sv
// Execute stage: pipeline register, ALU, optional iterative divider, store lane
// alignment and the data-SRAM request issued in the transfer cycle.
module vie_exe_stage
  import vie_exe_stage_pkg::*;
#(
  parameter bit DIV_ENABLE = 1'b1
) (
  input logic            clock,
  input logic            reset,
  vie_exe_stage_if.slave bus
);

  ds_bus_t     ds_in_s;
  ds_payload_t es_r;
  rs_bus_t     rs_s;
  logic        es_valid_r;
  logic        es_allowin_s, es_cango_s, es_to_ms_valid_s;
  logic        is_div_s, div_cango_s, mem_req_s, sram_en_s;
  logic [31:0] alu_res_s, div_res_s, fixres_s, mem_addr_s;

  assign ds_in_s = bus.dsbus_i;

  // Stage valid bit follows the decode valid whenever the stage accepts.
  always_ff @(posedge clock) begin
    if (reset) begin
      es_valid_r <= 1'b0;
    end else if (es_allowin_s) begin
      es_valid_r <= ds_in_s.valid;
    end else begin
      es_valid_r <= es_valid_r;
    end
  end

  // Payload register loads only on an accepted valid instruction; not reset.
  always_ff @(posedge clock) begin
    if (ds_in_s.valid && es_allowin_s) begin
      es_r <= ds_in_s.pl;
    end else begin
      es_r <= es_r;
    end
  end

  // Single-cycle ALU; divide codes fall through to the divider result.
  always_comb begin
    alu_res_s = 32'h0000_0000;
    case (es_r.alu_op)
      ALU_ADD:  alu_res_s = es_r.src1 + es_r.src2;
      ALU_SUB:  alu_res_s = es_r.src1 - es_r.src2;
      ALU_SLT:  alu_res_s = {31'd0, $signed(es_r.src1) < $signed(es_r.src2)};
      ALU_SLTU: alu_res_s = {31'd0, es_r.src1 < es_r.src2};
      ALU_AND:  alu_res_s = es_r.src1 & es_r.src2;
      ALU_OR:   alu_res_s = es_r.src1 | es_r.src2;
      ALU_XOR:  alu_res_s = es_r.src1 ^ es_r.src2;
      ALU_NOR:  alu_res_s = ~(es_r.src1 | es_r.src2);
      ALU_SLL:  alu_res_s = es_r.src2 << es_r.src1[4:0];
      ALU_SRL:  alu_res_s = es_r.src2 >> es_r.src1[4:0];
      ALU_SRA:  alu_res_s = $unsigned($signed(es_r.src2) >>> es_r.src1[4:0]);
      ALU_LUI:  alu_res_s = es_r.src2 << 16;
      default:  alu_res_s = 32'h0000_0000;
    endcase
  end

  assign is_div_s = (es_r.alu_op[3:2] == 2'b11);

  generate
    if (DIV_ENABLE) begin : g_div
      logic        div_busy_s, div_done_s;
      logic [31:0] div_quo_s, div_rem_s;

      vie_div u_div (
        .clock     (clock),
        .reset     (reset),
        .start     (es_valid_r && is_div_s),
        .signed_op (~es_r.alu_op[0]),
        .x         (es_r.src1),
        .y         (es_r.src2),
        .busy      (div_busy_s),
        .done      (div_done_s),
        .ack       (es_valid_r && bus.ms_allowin),
        .quo       (div_quo_s),
        .rem       (div_rem_s)
      );

      assign div_res_s   = es_r.alu_op[1] ? div_rem_s : div_quo_s;
      assign div_cango_s = div_done_s && !div_busy_s;
    end else begin : g_nodiv
      assign div_res_s   = 32'h0000_0000;
      assign div_cango_s = 1'b1;
    end
  endgenerate

  // Result select between the ALU and the divider.
  always_comb begin
    if (is_div_s) begin
      fixres_s = div_res_s;
    end else begin
      fixres_s = alu_res_s;
    end
  end

  assign es_cango_s       = !is_div_s || div_cango_s;
  assign es_to_ms_valid_s = es_valid_r && es_cango_s;
  assign es_allowin_s     = !es_valid_r || (es_cango_s && bus.ms_allowin);

  assign mem_addr_s = es_r.src1 + es_r.src2;
  assign mem_req_s  = es_r.load || es_r.store;
  assign sram_en_s  = es_to_ms_valid_s && bus.ms_allowin && mem_req_s;

  assign rs_s.valid        = es_to_ms_valid_s;
  assign rs_s.res_from_mem = es_r.load;
  assign rs_s.dest         = es_r.dest;
  assign rs_s.fixres       = fixres_s;
  assign rs_s.pc           = es_r.pc;

  assign bus.es_allowin      = es_allowin_s;
  assign bus.rsbus_o         = rs_s;
  assign bus.data_sram_en    = sram_en_s;
  assign bus.data_sram_wen   = (sram_en_s && es_r.store) ? store_wen(es_r.size, mem_addr_s[1:0]) : 4'b0000;
  assign bus.data_sram_addr  = {mem_addr_s[31:2], 2'b00};
  assign bus.data_sram_wdata = store_wdata(es_r.size, es_r.st_data);

endmodule
